// File: rtl/queue_calc_pkg.sv
// ---------------------------------------------------------------------------
// queue_calc_pkg
// Definitions shared by the queue calculator blocks: the controller, the
// operand queue and the ALU.
//   - Opcodes: the command opcodes plus the ALU NOP code.
//   - Response error codes.
//   - Controller state enum.
//   - Small opcode classification helpers.
// ---------------------------------------------------------------------------
package queue_calc_pkg;

  localparam logic [3:0] OP_PUSH = 4'b0000;
  localparam logic [3:0] OP_POP  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_REM  = 4'b0110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_EMPTY = 2'd1;
  localparam logic [1:0] ERR_FULL  = 2'd2;
  localparam logic [1:0] ERR_CALC  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_POP_A,
    ST_POP_B,
    ST_EXEC,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Legal opcodes are the contiguous range PUSH..REM.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_REM);
  endfunction

  // Two-operand ALU commands.
  function automatic logic op_is_binary(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SUB) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/queue_calc_ctrl.sv
// ---------------------------------------------------------------------------
// queue_calc_ctrl
// Sequencer for the queue calculator. It accepts one command at a time and
// is the only agent that strobes the operand queue. Binary commands pop two
// operands, present them to the external combinational ALU, and push the
// result back. Every accepted command ends with a one-cycle response.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_*           command handshake (cmd_ready high only in IDLE)
//   rsp_*           one-cycle response pulse with status and data
//   q_push/q_pop    queue strobes; q_wdata is the push data
//   q_rdata/q_empty/q_full/q_count   queue head and occupancy
//   alu_opcode      opcode to the ALU (NOP outside EXEC)
//   alu_operands    {opb, opa}
//   alu_result/alu_err   combinational ALU outputs
//   busy            high whenever a command is in flight
//   err_cnt         count of errored responses, saturating at 255
// ---------------------------------------------------------------------------
module queue_calc_ctrl
  import queue_calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [7:0]    cmd_val,
  output logic          rsp_valid,
  output logic [1:0]    rsp_err,
  output logic [7:0]    rsp_data,
  output logic          q_push,
  output logic          q_pop,
  output logic [7:0]    q_wdata,
  input  logic [7:0]    q_rdata,
  input  logic          q_empty,
  input  logic          q_full,
  input  logic [CW-1:0] q_count,
  output logic [3:0]    alu_opcode,
  output logic [15:0]   alu_operands,
  input  logic [7:0]    alu_result,
  input  logic          alu_err,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t     state_reg, state_next;
  logic [3:0] op_reg;
  logic [7:0] val_reg;
  logic [7:0] opa_reg;
  logic [7:0] opb_reg;
  logic [7:0] res_reg;
  logic [1:0] err_reg;
  logic [7:0] data_reg;
  logic [7:0] err_cnt_reg;

  logic [1:0] decode_err;
  logic       calc_err;
  logic       queue_full;

  // Treat the queue as full on either the flag or the count, so a PUSH can
  // never overrun even if the two disagree for a cycle.
  assign queue_full = q_full || (q_count >= DEPTH_C);

  always_comb begin
    decode_err = ERR_OK;
    if (!op_is_legal(op_reg)) begin
      decode_err = ERR_CALC;
    end else if (op_reg == OP_PUSH) begin
      if (queue_full) decode_err = ERR_FULL;
    end else if (op_reg == OP_POP) begin
      if (q_empty) decode_err = ERR_EMPTY;
    end else if (q_count < CW'(2)) begin
      decode_err = ERR_EMPTY;
    end
  end

  // Divide-by-zero is checked locally as well as via the ALU flag.
  assign calc_err = alu_err ||
                    (((op_reg == OP_DIV) || (op_reg == OP_REM)) && (opb_reg == 8'd0));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_wdata    = 8'd0;
    alu_opcode = OP_NOP;
    rsp_valid  = 1'b0;
    rsp_err    = ERR_OK;
    rsp_data   = 8'd0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (decode_err != ERR_OK)   state_next = ST_RESP;
        else if (op_reg == OP_PUSH) state_next = ST_WRITE;
        else                        state_next = ST_POP_A;
      end
      ST_POP_A: begin
        q_pop      = 1'b1;
        state_next = (op_reg == OP_POP) ? ST_RESP : ST_POP_B;
      end
      ST_POP_B: begin
        q_pop      = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode = op_reg;
        state_next = calc_err ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        q_push     = 1'b1;
        q_wdata    = (op_reg == OP_PUSH) ? val_reg : res_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_reg;
        rsp_data   = data_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A reset cycle aborts the command: no strobe or response may escape.
    if (rst) begin
      q_push    = 1'b0;
      q_pop     = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  // Operand, result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= OP_NOP;
      val_reg     <= 8'd0;
      opa_reg     <= 8'd0;
      opb_reg     <= 8'd0;
      res_reg     <= 8'd0;
      err_reg     <= ERR_OK;
      data_reg    <= 8'd0;
      err_cnt_reg <= 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            val_reg  <= cmd_val;
            err_reg  <= ERR_OK;
            data_reg <= 8'd0;
          end
        end
        ST_DECODE: begin
          err_reg <= decode_err;
          if ((decode_err == ERR_OK) && (op_reg == OP_PUSH)) data_reg <= val_reg;
        end
        ST_POP_A: begin
          opa_reg  <= q_rdata;
          data_reg <= q_rdata;  // POP response; binary ops overwrite in EXEC
        end
        ST_POP_B: opb_reg <= q_rdata;
        ST_EXEC: begin
          res_reg <= alu_result;
          if (calc_err) begin
            err_reg  <= ERR_CALC;
            data_reg <= 8'd0;
          end else begin
            data_reg <= alu_result;
          end
        end
        ST_RESP: begin
          if ((err_reg != ERR_OK) && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu_operands = {opb_reg, opa_reg};
  assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_queue_calc_ctrl
// Bench for queue_calc_ctrl. The bench supplies the operand queue and the
// ALU as behavioural models, and keeps a separate reference queue that is
// advanced per command from the calculator's arithmetic rules to predict
// every response, its latency and the number of queue strobes.
// ---------------------------------------------------------------------------
module tb_queue_calc_ctrl;
  import queue_calc_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = 4'd0;
  logic [7:0]    cmd_val = 8'd0;
  logic          rsp_valid;
  logic [1:0]    rsp_err;
  logic [7:0]    rsp_data;
  logic          q_push, q_pop;
  logic [7:0]    q_wdata;
  logic [7:0]    q_rdata = 8'd0;
  logic          q_empty = 1'b1;
  logic          q_full  = 1'b0;
  logic [CW-1:0] q_count = '0;
  logic [3:0]    alu_opcode;
  logic [15:0]   alu_operands;
  logic [7:0]    alu_result;
  logic          alu_err;
  logic          busy;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  queue_calc_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_val(cmd_val),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .q_push(q_push), .q_pop(q_pop), .q_wdata(q_wdata),
    .q_rdata(q_rdata), .q_empty(q_empty), .q_full(q_full), .q_count(q_count),
    .alu_opcode(alu_opcode), .alu_operands(alu_operands),
    .alu_result(alu_result), .alu_err(alu_err),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- environment: queue model driven by strobes ------------
  logic [7:0] env_q[$];
  int push_total = 0;
  int pop_total  = 0;
  int both_total = 0;

  always @(posedge clk) begin
    if (q_push && q_pop) both_total++;
    if (q_pop) begin
      pop_total++;
      if (env_q.size() > 0) void'(env_q.pop_front());
    end
    if (q_push) begin
      push_total++;
      env_q.push_back(q_wdata);
    end
    q_rdata <= (env_q.size() > 0) ? env_q[0] : 8'd0;
    q_empty <= (env_q.size() == 0);
    q_full  <= (env_q.size() >= DEPTH);
    q_count <= CW'(env_q.size());
  end

  // ---------------- environment: combinational ALU ------------------------
  always_comb begin
    logic [7:0]  a, b;
    logic [15:0] p;
    a = alu_operands[7:0];
    b = alu_operands[15:8];
    p = 16'(a) * 16'(b);
    alu_result = 8'd0;
    alu_err    = 1'b0;
    case (alu_opcode)
      OP_ADD: alu_result = a + b;
      OP_SUB: alu_result = a - b;
      OP_MUL: alu_result = p[7:0];
      OP_DIV: if (b == 0) alu_err = 1'b1; else alu_result = a / b;
      OP_REM: if (b == 0) alu_err = 1'b1; else alu_result = a % b;
      default: ;
    endcase
  end

  // ---------------- reference model ---------------------------------------
  logic [7:0] ref_q[$];
  int         ref_err_cnt = 0;

  function automatic logic [7:0] ref_arith(input logic [3:0] op, input int a, input int b);
    int r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b + 256;
      OP_MUL:  r = a * b;
      OP_DIV:  r = a / b;
      default: r = a % b;
    endcase
    return 8'(r % 256);
  endfunction

  // Issue one command; entered and left at a negedge while the DUT is IDLE.
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] val);
    int e_lat, e_push, e_pop, p0, o0, lat;
    logic [1:0] e_err;
    logic [7:0] e_data, g_data;
    logic [1:0] g_err;
    bit got;
    e_err = ERR_OK; e_data = 8'd0; e_push = 0; e_pop = 0; e_lat = 2;
    if (op > OP_REM) begin
      e_err = ERR_CALC;
    end else if (op == OP_PUSH) begin
      if (ref_q.size() >= DEPTH) e_err = ERR_FULL;
      else begin ref_q.push_back(val); e_data = val; e_push = 1; e_lat = 3; end
    end else if (op == OP_POP) begin
      if (ref_q.size() == 0) e_err = ERR_EMPTY;
      else begin e_data = ref_q.pop_front(); e_pop = 1; e_lat = 3; end
    end else if (ref_q.size() < 2) begin
      e_err = ERR_EMPTY;
    end else begin
      int a, b;
      a = int'(ref_q.pop_front());
      b = int'(ref_q.pop_front());
      e_pop = 2;
      if ((op == OP_DIV || op == OP_REM) && b == 0) begin
        e_err = ERR_CALC; e_lat = 5;
      end else begin
        e_data = ref_arith(op, a, b);
        ref_q.push_back(e_data);
        e_push = 1; e_lat = 6;
      end
    end
    if (e_err != ERR_OK && ref_err_cnt < 255) ref_err_cnt++;

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle: got %b need 1", cmd_ready);
    end
    p0 = push_total; o0 = pop_total;
    cmd_valid = 1'b1; cmd_op = op; cmd_val = val;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_val = 8'($urandom);
    got = 0; lat = 0; g_err = 0; g_data = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1; lat = n; g_err = rsp_err; g_data = rsp_data;
        break;
      end
    end
    $display("cmd op=%h val=%h -> valid=%0d err=%0d data=%h lat=%0d (expect err=%0d data=%h lat=%0d)",
             op, val, got, g_err, g_data, lat, e_err, e_data, e_lat);
    checks++;
    if (!got) begin
      errors++; $display("FAIL rsp_timeout: no rsp_valid within 12 cycles, need latency %0d", e_lat);
    end else begin
      if (lat != e_lat) begin errors++; $display("FAIL rsp_latency: got %0d need %0d", lat, e_lat); end
      checks++;
      if (g_err !== e_err) begin errors++; $display("FAIL rsp_err: got %0d need %0d", g_err, e_err); end
      checks++;
      if (g_data !== e_data) begin errors++; $display("FAIL rsp_data: got %h need %h", g_data, e_data); end
      checks++;
      if (alu_opcode !== OP_NOP) begin errors++; $display("FAIL alu_nop_in_resp: got %h need f", alu_opcode); end
    end
    checks++;
    if (push_total - p0 != e_push || pop_total - o0 != e_pop) begin
      errors++;
      $display("FAIL strobe_count: got push=%0d pop=%0d need push=%0d pop=%0d",
               push_total - p0, pop_total - o0, e_push, e_pop);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle: got %b need 0", rsp_valid); end
    checks++;
    if (err_cnt !== 8'(ref_err_cnt)) begin
      errors++; $display("FAIL err_cnt: got %0d need %0d", err_cnt, ref_err_cnt);
    end
    checks++;
    if (env_q.size() != ref_q.size() || (ref_q.size() > 0 && env_q[0] !== ref_q[0])) begin
      errors++;
      $display("FAIL queue_state: got size=%0d head=%h need size=%0d head=%h", env_q.size(),
               (env_q.size() > 0) ? env_q[0] : 8'd0, ref_q.size(), (ref_q.size() > 0) ? ref_q[0] : 8'd0);
    end
  endtask

  // Accept a command, then assert rst in cycle rst_cycle after the accept edge.
  task automatic reset_during(input logic [3:0] op, input logic [7:0] val,
                              input int rst_cycle, input int n_pops);
    int p0, o0, seen;
    p0 = push_total; o0 = pop_total;
    cmd_valid = 1'b1; cmd_op = op; cmd_val = val;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= rst_cycle; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_rst: got %b need 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_to_idle: got ready=%b busy=%b rsp_valid=%b need 1 0 0", cmd_ready, busy, rsp_valid);
    end
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    for (int i = 0; i < n_pops; i++) void'(ref_q.pop_front());
    ref_err_cnt = 0;
    $display("rst op=%h at cycle %0d -> push=%0d pop=%0d rsp=%0d", op, rst_cycle,
             push_total - p0, pop_total - o0, seen);
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_rsp: got %0d responses need 0", seen); end
    checks++;
    if (push_total - p0 != 0 || pop_total - o0 != n_pops) begin
      errors++;
      $display("FAIL rst_strobes: got push=%0d pop=%0d need push=0 pop=%0d",
               push_total - p0, pop_total - o0, n_pops);
    end
    checks++;
    if (env_q.size() != ref_q.size() || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_state: got qsize=%0d err_cnt=%0d need qsize=%0d err_cnt=0",
               env_q.size(), err_cnt, ref_q.size());
    end
  endtask

  task automatic drain();
    while (ref_q.size() > 0) do_cmd(OP_POP, 8'd0);
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 2'd0 || rsp_data !== 8'd0 ||
        q_push !== 1'b0 || q_pop !== 1'b0 || q_wdata !== 8'd0 || alu_opcode !== OP_NOP ||
        alu_operands !== 16'd0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b rv=%b re=%0d rd=%h push=%b pop=%b wd=%h aop=%h aopd=%h busy=%b ec=%0d",
               cmd_ready, rsp_valid, rsp_err, rsp_data, q_push, q_pop, q_wdata,
               alu_opcode, alu_operands, busy, err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    do_cmd(OP_PUSH, 8'd5);  do_cmd(OP_PUSH, 8'd3);  do_cmd(OP_SUB, 8'd0);   // 2
    do_cmd(OP_PUSH, 8'd20); do_cmd(OP_PUSH, 8'd20); do_cmd(OP_MUL, 8'd0);   // 0x90
    do_cmd(OP_ADD, 8'd0);                                                   // 2+0x90
    do_cmd(OP_PUSH, 8'd3);  do_cmd(OP_PUSH, 8'd7);  do_cmd(OP_SUB, 8'd0);   // 3-7 wraps
    drain();
  endtask

  task automatic test_div_zero();
    do_cmd(OP_PUSH, 8'd7); do_cmd(OP_PUSH, 8'd0); do_cmd(OP_DIV, 8'd0);
    do_cmd(OP_PUSH, 8'd7); do_cmd(OP_PUSH, 8'd0); do_cmd(OP_REM, 8'd0);
    do_cmd(OP_PUSH, 8'd200); do_cmd(OP_PUSH, 8'd7); do_cmd(OP_DIV, 8'd0);
    do_cmd(OP_PUSH, 8'd200); do_cmd(OP_PUSH, 8'd7); do_cmd(OP_REM, 8'd0);
    drain();
  endtask

  task automatic test_underflow_illegal();
    do_cmd(OP_PUSH, 8'd42);
    do_cmd(OP_ADD, 8'd0);
    do_cmd(4'b0111, 8'd0);
    do_cmd(4'b1111, 8'd0);
    drain();
    do_cmd(OP_POP, 8'd0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH, 8'(i * 17 + 1));
    do_cmd(OP_PUSH, 8'd9);
    drain();
    do_cmd(OP_POP, 8'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int sel;
      logic [3:0] op;
      logic [7:0] v;
      sel = int'($urandom_range(0, 9));
      v = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      case (sel)
        0, 1, 2: op = OP_PUSH;
        3:       op = OP_POP;
        4:       op = OP_ADD;
        5:       op = OP_MUL;
        6:       op = OP_SUB;
        7:       op = OP_DIV;
        8:       op = OP_REM;
        default: op = 4'($urandom_range(7, 15));
      endcase
      do_cmd(op, v);
    end
    drain();
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 258; i++) do_cmd(4'($urandom_range(7, 15)), 8'd0);
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_saturate: got %0d need 255", err_cnt); end
  endtask

  task automatic test_reset_mid_cmd();
    do_cmd(OP_PUSH, 8'd11); do_cmd(OP_PUSH, 8'd22);
    reset_during(OP_ADD, 8'd0, 4, 2);      // rst while in EXEC
    do_cmd(OP_PUSH, 8'd33);
    reset_during(OP_PUSH, 8'd44, 2, 0);    // rst while in WRITE: push suppressed
    reset_during(OP_POP, 8'd0, 2, 0);      // rst while in POP_A: pop suppressed
    do_cmd(OP_POP, 8'd0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_underflow_illegal();
    test_full();
    test_random();
    test_err_saturate();
    test_reset_mid_cmd();
    checks++;
    if (both_total != 0) begin
      errors++; $display("FAIL push_pop_overlap: got %0d overlapping cycles need 0", both_total);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_calc_ctrl.md
# queue_calc_ctrl

Sequencer for the queue calculator. It accepts one command at a time over a valid/ready handshake and drives the operand queue's push/pop strobes. It presents registered operands and an opcode to the combinational ALU, writes results back to the queue, and returns a one-cycle response with status. It sits between the command source and the queue + ALU pair and is the only agent that touches the queue.

## Interface
- DEPTH, 8: queue depth in entries.
- CW, $clog2(DEPTH)+1: width of q_count.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept; high only in IDLE.
- cmd_op  in  4  opcode: PUSH 0000, POP 0001, ADD 0010, MUL 0011, SUB 0100, DIV 0101, REM 0110; others illegal.
- cmd_val  in  8  immediate for PUSH.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_err  out  2  0 OK, 1 EMPTY (underflow), 2 FULL (overflow), 3 CALC (divide by zero or illegal opcode).
- rsp_data  out  8  pushed value, popped value, or result; 0 on error.
- q_push  out  1  push q_wdata at this edge.
- q_pop  out  1  remove head at this edge.
- q_wdata  out  8  push data.
- q_rdata  in  8  current head; valid when !q_empty.
- q_empty  in  1  queue empty.
- q_full  in  1  queue full.
- q_count  in  CW  occupancy.
- alu_opcode  out  4  ALU opcode; NOP 1111 outside EXEC.
- alu_operands  out  16  {opb, opa}.
- alu_result  in  8  ALU result, combinational from alu_opcode/alu_operands.
- alu_err  in  1  ALU divide-by-zero flag.
- busy  out  1  high in every state except IDLE.
- err_cnt  out  8  errored commands, saturating at 255.

## Operation
- States: IDLE, DECODE, POP_A, POP_B, EXEC, WRITE, RESP.
- IDLE: cmd_ready=1. When cmd_valid, latch op/val and go to DECODE.
- DECODE:
  - Illegal op → CALC.
  - PUSH with q_full → FULL.
  - POP with q_empty → EMPTY.
  - Binary op with q_count<2 → EMPTY.
  - Any error → RESP with the error code; the queue is never strobed.
  - PUSH → WRITE (q_wdata=cmd_val).
  - POP and binary ops → POP_A.
- POP_A: q_pop=1; opa←q_rdata (older operand). POP → RESP with rsp_data=opa. Binary → POP_B.
- POP_B: q_pop=1; opb←q_rdata.
- EXEC: alu_opcode=op, alu_operands={opb,opa}.
  - res←alu_result at the cycle-end edge.
  - If alu_err or (DIV/REM with opb==0): CALC → RESP. Both operands stay consumed and nothing is pushed.
  - Otherwise → WRITE.
- Arithmetic, all 8-bit modulo 2^8 with the upper product bits discarded:
  - ADD = opa+opb.
  - SUB = opa−opb.
  - MUL = (opa*opb)[7:0].
  - DIV = opa/opb.
  - REM = opa%opb.
- WRITE: q_push=1, q_wdata = val (PUSH) or res. → RESP.
- RESP: rsp_valid=1, rsp_err and rsp_data from registers. err_cnt increments (saturating) if rsp_err≠0. → IDLE.
- q_push and q_pop are never high in the same cycle. Each is high for at most one cycle per strobe.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: cmd_ready=1; rsp_valid=0, rsp_err=0, rsp_data=0; q_push=0, q_pop=0, q_wdata=0; alu_opcode=1111, alu_operands=0; busy=0; err_cnt=0.
- Reset in any state forces IDLE at the next edge. Any strobe asserted in that cycle is suppressed. A partially executed command gets no response.
- With the accept edge as E0, rsp_valid is high in cycle n after E0:
  - PUSH: 3.
  - POP: 3.
  - Binary OK: 6.
  - DIV/REM by zero: 5.
  - DECODE error: 2.
- The next command can be accepted in the cycle after RESP, so throughput is one command per (latency+1) cycles.
- cmd_valid outside IDLE is ignored. The source holds the command until cmd_ready.

## Structure
- Package queue_calc_pkg holds:
  - Opcode localparams, including NOP 1111.
  - Error codes OK/EMPTY/FULL/CALC.
  - State enum.
  - Shared by ALU, queue and this block.
- No sub-module: FSM, operand/result registers and the saturating counter live in one module.

## Test plan
- PUSH 5, PUSH 3, SUB → rsp_data=2, OK at cycle 6; q_count=1, head 2; exactly two q_pop and one q_push.
- PUSH 20, PUSH 20, MUL → rsp_data=0x90 (400 mod 256), OK.
- PUSH 7, PUSH 0, DIV → rsp_err=CALC at cycle 5; q_count=0; no q_push; err_cnt=1. Repeat with REM → err_cnt=2.
- One entry queued, ADD → EMPTY at cycle 2; q_pop never asserted; q_count stays 1. Opcode 0111 → CALC.
- DEPTH pushes then PUSH 9 → FULL; no q_push. POP on empty queue → EMPTY. 256 errors → err_cnt holds 255.
- rst asserted during EXEC of ADD → next cycle IDLE, cmd_ready=1, q_push never asserted, no rsp_valid.
